wght_acc_seq: RTL and testbench
===============================

Name: wght_acc_seq

Overview:
- Control FSM that sequences a bank of weight accumulators through one backprop-through-time weight-gradient pass.
- Clears the accumulators, then walks timesteps from last to first. It asserts the accumulate enable once per timestep, when the delta/input datapath reports valid operands.
- Ends with a one-cycle weight-update strobe and a done pulse.
- Sits between the LSTM backprop top-level controller and the per-weight accumulator array. All accumulators share o_acc_clr and o_acc_en.

Parameters:
- TW, 8, width of timestep count and index.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  pass request; sampled only in IDLE.
- i_n_step  input  TW  number of timesteps for the pass; sampled with i_start.
- i_valid  input  1  datapath has delta/input operands for timestep o_t_idx.
- i_abort  input  1  synchronous abort of a running pass.
- o_busy  output  1  high in every state except IDLE.
- o_acc_clr  output  1  one-cycle clear to the accumulators.
- o_acc_en  output  1  accumulate enable; mux select into the accumulators.
- o_t_idx  output  TW  timestep whose operands are requested.
- o_last  output  1  o_t_idx==0 while in ACCUM.
- o_upd  output  1  one-cycle strobe: accumulated gradients are final, apply the weight update.
- o_done  output  1  one-cycle pass-complete pulse.

Behaviour:
- Reset: state=IDLE. All outputs 0, o_t_idx=0, latched count=0. Reset mid-pass discards the pass; no o_upd and no o_done are issued.
- States: IDLE, CLEAR, ACCUM, UPDATE, DONE. State, o_t_idx and the latched count are registered. Output decode follows.
- IDLE:
  - i_start=1 and i_n_step!=0: latch n_step, next state CLEAR.
  - i_start=1 and i_n_step==0: next state DONE; no clear, no update.
  - i_start while not IDLE is ignored; there is no queueing.
- CLEAR: o_acc_clr=1 for exactly this cycle. o_t_idx<=n_step-1 at the clock edge. Next state ACCUM.
- ACCUM:
  - o_acc_en = i_valid, combinational; only in ACCUM.
  - When i_valid=1 and o_t_idx!=0: decrement o_t_idx at the clock edge; stay in ACCUM.
  - When i_valid=1 and o_t_idx==0: next state UPDATE.
  - When i_valid=0: hold; the wait is unbounded.
  - i_valid outside ACCUM is ignored; o_acc_en stays 0.
- UPDATE: o_upd=1 for one cycle. Next state DONE.
- DONE: o_done=1 for one cycle. Next state IDLE.
- Latency with i_valid held high:
  - Start accepted at edge k gives o_acc_clr in cycle k+1.
  - o_acc_en in cycles k+2 .. k+1+n_step.
  - o_upd in cycle k+2+n_step; o_done in cycle k+3+n_step.
- Abort:
  - i_abort=1 in CLEAR or ACCUM: next state IDLE.
  - o_acc_en is forced 0 in that cycle, even if i_valid=1.
  - No o_upd and no o_done are issued. o_acc_clr=1 in the abort cycle, so the partial sums are discarded.
  - i_abort in IDLE, UPDATE or DONE has no effect.
  - Abort and start in the same cycle: abort wins; the start is not accepted unless the state is IDLE.
- Wrap-around:
  - n_step = 2^TW-1 is the maximum.
  - o_t_idx never decrements below 0 and never wraps.
- o_busy = (state!=IDLE), decoded from the registered state.

Test Plan:
- Nominal: i_n_step=3 with i_start pulsed at edge 0, i_valid held 1.
  - o_acc_clr in cycle 1.
  - o_acc_en in cycles 2,3,4 with o_t_idx=2,1,0; o_last only in cycle 4.
  - o_upd in cycle 5, o_done in cycle 6.
  - o_busy high in cycles 1-6; with 1.0 (Q8.24) operands the accumulator totals 3.0.
- Stall: i_n_step=2, i_valid toggling 0,1,0,0,1 through ACCUM.
  - o_acc_en exactly when i_valid=1; o_t_idx holds during stalls.
  - o_upd follows the second accepted step.
- Zero count: i_n_step=0 with i_start → o_done one cycle later; o_acc_clr, o_acc_en and o_upd stay 0.
- Abort: i_n_step=4, i_abort on the 2nd ACCUM cycle with i_valid=1.
  - o_acc_en=0 and o_acc_clr=1 in that cycle.
  - Next cycle IDLE; no o_upd or o_done.
- Reset/restart: assert rst asynchronously mid-ACCUM.
  - All outputs 0 immediately.
  - After release, a fresh i_start with n_step=1 runs a complete pass.
  - i_start pulsed during a busy pass is ignored.

Source files
------------

// File: rtl/wght_acc_seq_if.sv
// Handshake bundle between the BPTT controller, the weight-gradient
// sequencer and the shared accumulator controls.
interface wght_acc_seq_if #(
  parameter int TW = 8
);
  logic          i_start;
  logic [TW-1:0] i_n_step;
  logic          i_valid;
  logic          i_abort;
  logic          o_busy;
  logic          o_acc_clr;
  logic          o_acc_en;
  logic [TW-1:0] o_t_idx;
  logic          o_last;
  logic          o_upd;
  logic          o_done;

  modport master (
    output i_start, i_n_step, i_valid, i_abort,
    input  o_busy, o_acc_clr, o_acc_en, o_t_idx, o_last, o_upd, o_done
  );

  modport slave (
    input  i_start, i_n_step, i_valid, i_abort,
    output o_busy, o_acc_clr, o_acc_en, o_t_idx, o_last, o_upd, o_done
  );
endinterface

// File: rtl/wght_acc_seq.sv
// Weight-gradient accumulation sequencer: clear, walk timesteps last-to-first,
// then strobe the weight update and signal completion.
//
// state  | meaning
// IDLE   | waiting for a pass request
// CLEAR  | clearing accumulators, loading first timestep index
// ACCUM  | accumulating one timestep per valid operand beat
// UPDATE | gradients final, weight update strobe
// DONE   | pass-complete pulse
module wght_acc_seq #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  wght_acc_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACCUM  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t        state_q;
  logic [TW-1:0] t_idx_q;
  logic [TW-1:0] n_step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      t_idx_q  <= '0;
      n_step_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            if (bus.i_n_step != '0) begin
              n_step_q <= bus.i_n_step;
              state_q  <= CLEAR;
            end else begin
              state_q  <= DONE;
            end
          end
        end
        CLEAR: begin
          if (bus.i_abort) begin
            t_idx_q <= '0;
            state_q <= IDLE;
          end else begin
            t_idx_q <= n_step_q - TW'(1);
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          // Abort takes priority over an accepted operand beat.
          if (bus.i_abort) begin
            t_idx_q <= '0;
            state_q <= IDLE;
          end else if (bus.i_valid) begin
            if (t_idx_q != '0) begin
              t_idx_q <= t_idx_q - TW'(1);
            end else begin
              state_q <= UPDATE;
            end
          end
        end
        UPDATE: state_q <= DONE;
        DONE:   state_q <= IDLE;
        default: begin
          t_idx_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Abort in ACCUM re-asserts clear so partial sums never survive.
  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_acc_clr = (state_q == CLEAR) || ((state_q == ACCUM) && bus.i_abort);
  assign bus.o_acc_en  = (state_q == ACCUM) && bus.i_valid && !bus.i_abort;
  assign bus.o_t_idx   = t_idx_q;
  assign bus.o_last    = (state_q == ACCUM) && (t_idx_q == '0);
  assign bus.o_upd     = (state_q == UPDATE);
  assign bus.o_done    = (state_q == DONE);

endmodule

// File: tb/tb_wght_acc_seq.sv
// Directed bench for wght_acc_seq: nominal, stall, zero-count, abort and
// reset/restart passes against hand-computed cycle-by-cycle outputs.
module tb_wght_acc_seq;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] acc_q;

  wght_acc_seq_if #(.TW(TW)) bus ();

  wght_acc_seq #(.TW(TW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single Q8.24 accumulator fed a constant 1.0 operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               acc_q <= '0;
    else if (bus.o_acc_clr) acc_q <= '0;
    else if (bus.o_acc_en)  acc_q <= acc_q + 32'h0100_0000;
  end

  // flags = {busy, acc_clr, acc_en, last, upd, done}
  task automatic chk(input string tag, input logic [5:0] flags, input logic [TW-1:0] t);
    logic [TW+5:0] obs;
    logic [TW+5:0] exp;
    obs = {bus.o_busy, bus.o_acc_clr, bus.o_acc_en, bus.o_last, bus.o_upd, bus.o_done, bus.o_t_idx};
    exp = {flags, t};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_acc(input string tag, input logic [31:0] exp);
    checks++;
    assert (acc_q === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, acc_q, exp);
    end
  endtask

  // Advance past the next rising edge; inputs then change, and checks run #1 later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start  = 1'b0;
    bus.i_n_step = '0;
    bus.i_valid  = 1'b0;
    bus.i_abort  = 1'b0;
    #1;
    chk("reset_hold", 6'b000000, 8'd0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("reset_state", 6'b000000, 8'd0);

    // Nominal pass: n=3, valid held high.
    bus.i_start = 1'b1; bus.i_n_step = 8'd3; bus.i_valid = 1'b1;
    #1; chk("nom_c0_idle", 6'b000000, 8'd0);
    cyc(); bus.i_start = 1'b0; #1; chk("nom_c1_clr", 6'b110000, 8'd0);
    cyc(); #1; chk("nom_c2_acc", 6'b101000, 8'd2);
    cyc(); #1; chk("nom_c3_acc", 6'b101000, 8'd1);
    cyc(); #1; chk("nom_c4_last", 6'b101100, 8'd0);
    cyc(); #1; chk("nom_c5_upd", 6'b100010, 8'd0);
    chk_acc("nom_acc_3p0", 32'h0300_0000);
    cyc(); #1; chk("nom_c6_done", 6'b100001, 8'd0);
    cyc(); #1; chk("nom_c7_idle", 6'b000000, 8'd0);

    // Stall pass: n=2, valid 0,1,0,0,1 through ACCUM.
    bus.i_start = 1'b1; bus.i_n_step = 8'd2; bus.i_valid = 1'b0;
    cyc(); bus.i_start = 1'b0; #1; chk("stl_c1_clr", 6'b110000, 8'd0);
    cyc(); bus.i_valid = 1'b0; #1; chk("stl_c2_wait", 6'b100000, 8'd1);
    cyc(); bus.i_valid = 1'b1; #1; chk("stl_c3_acc", 6'b101000, 8'd1);
    cyc(); bus.i_valid = 1'b0; #1; chk("stl_c4_wait", 6'b100100, 8'd0);
    cyc(); bus.i_valid = 1'b0; #1; chk("stl_c5_wait", 6'b100100, 8'd0);
    cyc(); bus.i_valid = 1'b1; #1; chk("stl_c6_acc", 6'b101100, 8'd0);
    cyc(); bus.i_valid = 1'b0; #1; chk("stl_c7_upd", 6'b100010, 8'd0);
    chk_acc("stl_acc_2p0", 32'h0200_0000);
    cyc(); #1; chk("stl_c8_done", 6'b100001, 8'd0);
    cyc(); #1; chk("stl_c9_idle", 6'b000000, 8'd0);

    // Zero-count pass: straight to DONE.
    bus.i_start = 1'b1; bus.i_n_step = 8'd0; bus.i_valid = 1'b1;
    cyc(); bus.i_start = 1'b0; #1; chk("zero_c1_done", 6'b100001, 8'd0);
    cyc(); #1; chk("zero_c2_idle", 6'b000000, 8'd0);

    // Abort on the second ACCUM cycle with valid high.
    bus.i_start = 1'b1; bus.i_n_step = 8'd4; bus.i_valid = 1'b1;
    cyc(); bus.i_start = 1'b0; #1; chk("abt_c1_clr", 6'b110000, 8'd0);
    cyc(); #1; chk("abt_c2_acc", 6'b101000, 8'd3);
    cyc(); bus.i_abort = 1'b1; #1; chk("abt_c3_abort", 6'b110000, 8'd2);
    cyc(); bus.i_abort = 1'b0; #1; chk("abt_c4_idle", 6'b000000, 8'd0);
    chk_acc("abt_acc_clr", 32'h0000_0000);
    bus.i_valid = 1'b0;
    cyc(); #1; chk("abt_c5_idle", 6'b000000, 8'd0);

    // Async reset mid-ACCUM, then a fresh n=1 pass.
    bus.i_start = 1'b1; bus.i_n_step = 8'd4; bus.i_valid = 1'b1;
    cyc(); bus.i_start = 1'b0; #1; chk("rst_c1_clr", 6'b110000, 8'd0);
    cyc(); #1; chk("rst_c2_acc", 6'b101000, 8'd3);
    rst = 1'b1; #1; chk("rst_async", 6'b000000, 8'd0);
    cyc(); rst = 1'b0; #1; chk("rst_released", 6'b000000, 8'd0);
    bus.i_start = 1'b1; bus.i_n_step = 8'd1; bus.i_valid = 1'b1;
    cyc(); bus.i_start = 1'b0; #1; chk("rs_c1_clr", 6'b110000, 8'd0);
    cyc(); #1; chk("rs_c2_last", 6'b101100, 8'd0);
    cyc(); bus.i_start = 1'b1; bus.i_n_step = 8'd5; #1; chk("rs_c3_upd", 6'b100010, 8'd0);
    cyc(); #1; chk("rs_c4_done", 6'b100001, 8'd0);
    cyc(); bus.i_start = 1'b0; #1; chk("rs_c5_idle", 6'b000000, 8'd0);
    cyc(); #1; chk("rs_c6_idle", 6'b000000, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
